// File: rtl/spawn_scanner.sv
// Sequential spawn-placement search: captures the top two grid rows and a piece mask on start,
// walks candidate column offsets one per cycle, and reports the first fit with the merged image.
module spawn_scanner #(
  parameter int GRID_W       = 10,
  parameter int PIECE_W      = 4,
  parameter int COLOR_W      = 3,
  parameter int ROW_BASE     = 21,
  parameter int CENTER_FIRST = 0
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    start,
  input  logic [1:0][PIECE_W-1:0]                 shape_mask,
  input  logic [COLOR_W-1:0]                      color,
  input  logic [GRID_W-1:0][COLOR_W-1:0]          row0,
  input  logic [GRID_W-1:0][COLOR_W-1:0]          row1,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    valid,
  output logic [$clog2(GRID_W)-1:0]               col_ref,
  output logic [4:0]                              row_ref,
  output logic [1:0][GRID_W-1:0][COLOR_W-1:0]     row01_out
);

  localparam int N  = GRID_W - PIECE_W + 1;
  localparam int CW = $clog2(GRID_W);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  typedef logic [1:0][GRID_W-1:0][COLOR_W-1:0] img_t;

  state_t                  state;
  logic [CW-1:0]           k;
  img_t                    cap_rows;
  logic [1:0][PIECE_W-1:0] cap_mask;
  logic [COLOR_W-1:0]      cap_color;

  logic [CW-1:0] cand_tbl [GRID_W];
  logic [CW-1:0] cand;
  logic [CW-1:0] idx;
  logic          fit;
  img_t          merged;

  // Step index -> offset. Centre-out walks c, c-1, c+1, ... in signed space, dropping
  // out-of-range values, so the table holds exactly N distinct offsets.
  function automatic int cand_at(int kk);
    int c, cnt, v, res;
    c = (N - 1) / 2;
    cnt = 0;
    res = 0;
    if (CENTER_FIRST == 0) return kk;
    for (int i = 0; i < 2 * N; i++) begin
      v = (i == 0) ? c : ((i % 2) == 1) ? c - (i + 1) / 2 : c + i / 2;
      if (v >= 0 && v < N) begin
        if (cnt == kk) res = v;
        cnt++;
      end
    end
    return res;
  endfunction

  for (genvar g = 0; g < GRID_W; g++) begin : g_cand
    if (g < N) begin : g_live
      assign cand_tbl[g] = CW'(cand_at(g));
    end else begin : g_pad
      assign cand_tbl[g] = '0;
    end
  end

  always_comb begin
    cand   = cand_tbl[k];
    fit    = 1'b1;
    merged = cap_rows;
    idx    = '0;
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < PIECE_W; j++) begin
        idx = cand + CW'(j);
        if (cap_mask[r][j]) begin
          if (cap_rows[r][idx] != '0) fit = 1'b0;
          merged[r][idx] = cap_color;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      cap_rows  <= '0;
      cap_mask  <= '0;
      cap_color <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      valid     <= 1'b0;
      col_ref   <= '0;
      row_ref   <= '0;
      row01_out <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cap_rows  <= {row1, row0};
          cap_mask  <= shape_mask;
          cap_color <= color;
          k         <= '0;
          // Nothing to place: report failure without scanning.
          if (shape_mask == '0 || color == '0) begin
            state     <= DONE;
            done      <= 1'b1;
            valid     <= 1'b0;
            col_ref   <= '0;
            row_ref   <= '0;
            row01_out <= {row1, row0};
          end else begin
            state <= SCAN;
            busy  <= 1'b1;
          end
        end
        SCAN: begin
          if (fit) begin
            state     <= DONE;
            done      <= 1'b1;
            busy      <= 1'b0;
            valid     <= 1'b1;
            col_ref   <= cand;
            row_ref   <= 5'(ROW_BASE);
            row01_out <= merged;
          end else if (k == CW'(N - 1)) begin
            state     <= DONE;
            done      <= 1'b1;
            busy      <= 1'b0;
            valid     <= 1'b0;
            col_ref   <= '0;
            row_ref   <= '0;
            row01_out <= cap_rows;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spawn_scanner.sv
// Scoreboard bench for spawn_scanner: three instances (left-to-right, centre-out, full-width piece)
// share grid rows; directed requests push expected results that per-instance monitors pop on done.
module tb_spawn_scanner;

  typedef logic [1:0][9:0][2:0] img_t;
  typedef struct {
    logic       valid;
    logic [3:0] col;
    logic [4:0] row;
    img_t       img;
    int         lat;
    int         t0;
  } exp_t;

  logic clk = 0, rst_n = 0;
  logic start0 = 0, start1 = 0, start2 = 0;
  logic [1:0][3:0] mask = '0;
  logic [1:0][9:0] mask2 = '0;
  logic [2:0] color = '0;
  logic [9:0][2:0] r0 = '0, r1 = '0;

  logic busy0, done0, valid0, busy1, done1, valid1, busy2, done2, valid2;
  logic [3:0] col0, col1, col2;
  logic [4:0] rr0, rr1, rr2;
  img_t img0, img1, img2;

  int checks = 0, errors = 0, cyc = 0;
  exp_t q0[$], q1[$], q2[$];

  spawn_scanner #(.CENTER_FIRST(0)) dut0 (.clk(clk), .rst_n(rst_n), .start(start0), .shape_mask(mask),
    .color(color), .row0(r0), .row1(r1), .busy(busy0), .done(done0), .valid(valid0), .col_ref(col0),
    .row_ref(rr0), .row01_out(img0));
  spawn_scanner #(.CENTER_FIRST(1)) dut1 (.clk(clk), .rst_n(rst_n), .start(start1), .shape_mask(mask),
    .color(color), .row0(r0), .row1(r1), .busy(busy1), .done(done1), .valid(valid1), .col_ref(col1),
    .row_ref(rr1), .row01_out(img1));
  spawn_scanner #(.PIECE_W(10)) dut2 (.clk(clk), .rst_n(rst_n), .start(start2), .shape_mask(mask2),
    .color(color), .row0(r0), .row1(r1), .busy(busy2), .done(done2), .valid(valid2), .col_ref(col2),
    .row_ref(rr2), .row01_out(img2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare(string tag, exp_t e, logic v, logic [3:0] c, logic [4:0] r, img_t im, logic b);
    chk({tag, ".latency"}, 64'(cyc - e.t0), 64'(e.lat));
    chk({tag, ".valid"}, 64'(v), 64'(e.valid));
    chk({tag, ".col_ref"}, 64'(c), 64'(e.col));
    chk({tag, ".row_ref"}, 64'(r), 64'(e.row));
    chk({tag, ".row01_out"}, 64'(im), 64'(e.img));
    chk({tag, ".busy_at_done"}, 64'(b), 64'd0);
  endtask

  task automatic unexpected(string tag);
    checks++; errors++;
    $display("FAIL %s: done pulse with no pending request", tag);
  endtask

  always @(negedge clk) if (rst_n && done0) begin
    if (q0.size() == 0) unexpected("dut0"); else compare("dut0", q0.pop_front(), valid0, col0, rr0, img0, busy0);
  end
  always @(negedge clk) if (rst_n && done1) begin
    if (q1.size() == 0) unexpected("dut1"); else compare("dut1", q1.pop_front(), valid1, col1, rr1, img1, busy1);
  end
  always @(negedge clk) if (rst_n && done2) begin
    if (q2.size() == 0) unexpected("dut2"); else compare("dut2", q2.pop_front(), valid2, col2, rr2, img2, busy2);
  end

  function automatic img_t fill(img_t im, int r, int lo, int hi, logic [2:0] v);
    for (int i = lo; i <= hi; i++) im[r][i] = v;
    return im;
  endfunction

  function automatic exp_t mk(logic v, logic [3:0] c, logic [4:0] r, img_t im, int lat);
    exp_t e;
    e.valid = v; e.col = c; e.row = r; e.img = im; e.lat = lat; e.t0 = 0;
    return e;
  endfunction

  // Pulse start on one instance (cycle 0 = cycle start is high) and queue its expectation.
  task automatic issue(int which, exp_t e);
    @(posedge clk); #1;
    e.t0 = cyc;
    case (which)
      0: begin q0.push_back(e); start0 = 1; end
      1: begin q1.push_back(e); start1 = 1; end
      default: begin q2.push_back(e); start2 = 1; end
    endcase
    @(posedge clk); #1;
    start0 = 0; start1 = 0; start2 = 0;
  endtask

  task automatic settle();
    repeat (12) @(posedge clk);
  endtask

  img_t im;
  int t0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy", 64'(busy0), 0);
    chk("reset.done", 64'(done0), 0);
    chk("reset.valid", 64'(valid0), 0);
    chk("reset.col_ref", 64'(col0), 0);
    chk("reset.row_ref", 64'(rr0), 0);
    chk("reset.row01_out", 64'(img0), 0);
    rst_n = 1;

    // Empty rows, bottom 0111 -> offset 0
    mask[0] = 4'b0000; mask[1] = 4'b0111; color = 3'd5;
    issue(0, mk(1, 0, 21, fill('0, 1, 0, 2, 5), 2));
    settle();

    // row1 cells 0..3 blocked -> offset 4, done in cycle 6
    for (int i = 0; i < 4; i++) r1[i] = 3'd2;
    im = fill(fill('0, 1, 0, 3, 2), 1, 4, 6, 5);
    issue(0, mk(1, 4, 21, im, 6));
    settle();

    // Centre-out, empty rows, 0110/0110 -> offset 3
    r1 = '0; mask[0] = 4'b0110; mask[1] = 4'b0110; color = 3'd3;
    issue(1, mk(1, 3, 21, fill(fill('0, 0, 4, 5, 3), 1, 4, 5, 3), 2));
    settle();

    // Columns 4,5 blocked in row0: 3,2,4 overlap, 1 fits
    r0[4] = 3'd1; r0[5] = 3'd1;
    im = fill(fill(fill('0, 0, 4, 5, 1), 0, 2, 3, 3), 1, 2, 3, 3);
    issue(1, mk(1, 1, 21, im, 5));
    settle();

    // row1 full, bottom 1111 -> no fit, done in cycle 8
    r0 = '0; for (int i = 0; i < 10; i++) r1[i] = 3'd7;
    mask[0] = 4'b0000; mask[1] = 4'b1111; color = 3'd2;
    issue(0, mk(0, 0, 0, fill('0, 1, 0, 9, 7), 8));
    settle();

    // Inputs change and start re-pulses mid-scan; result uses captured data
    r1 = '0; r0[0] = 3'd1; r0[1] = 3'd1; r0[2] = 3'd1;
    mask[0] = 4'b1111; mask[1] = 4'b0000; color = 3'd4;
    issue(0, mk(1, 3, 21, fill(fill('0, 0, 0, 2, 1), 0, 3, 6, 4), 5));
    r0 = '0; for (int i = 0; i < 10; i++) r1[i] = 3'd6;
    start0 = 1; @(posedge clk); #1; start0 = 0;
    settle();

    // Reset during scan at cycle 3: outputs clear at once, no done
    r0 = '0; for (int i = 0; i < 10; i++) r1[i] = 3'd7;
    mask[0] = 4'b0000; mask[1] = 4'b1111; color = 3'd2;
    @(posedge clk); #1;
    t0 = cyc; start0 = 1;
    @(posedge clk); #1; start0 = 0;
    chk("midscan.busy_before_reset", 64'(busy0), 1);
    repeat (2) @(posedge clk);
    #1; rst_n = 0; #1;
    chk("midrst.busy", 64'(busy0), 0);
    chk("midrst.valid", 64'(valid0), 0);
    chk("midrst.col_ref", 64'(col0), 0);
    chk("midrst.row_ref", 64'(rr0), 0);
    chk("midrst.row01_out", 64'(img0), 0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1;
    settle();

    // Normal operation after reset
    r1 = '0; mask[0] = 4'b0000; mask[1] = 4'b0111; color = 3'd5;
    issue(0, mk(1, 0, 21, fill('0, 1, 0, 2, 5), 2));
    settle();

    // Degenerate requests: empty mask, colour 0 -> done in cycle 1
    r0[9] = 3'd6; mask = '0;
    issue(0, mk(0, 0, 0, fill('0, 0, 9, 9, 6), 1));
    settle();
    mask[0] = 4'b0110; mask[1] = 4'b0110; color = 3'd0;
    issue(1, mk(0, 0, 0, fill('0, 0, 9, 9, 6), 1));
    settle();

    // Full-width piece: single candidate, done in cycle 2
    r0 = '0; mask2[0] = 10'h3FF; mask2[1] = '0; color = 3'd1;
    issue(2, mk(1, 0, 21, fill('0, 0, 0, 9, 1), 2));
    settle();
    r0[9] = 3'd3;
    issue(2, mk(0, 0, 0, fill('0, 0, 9, 9, 3), 2));
    settle();

    chk("drain.q0", 64'(q0.size()), 0);
    chk("drain.q1", 64'(q1.size()), 0);
    chk("drain.q2", 64'(q2.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spawn_scanner.md
Name: spawn_scanner

Overview:
- Sequential, parametrised successor to the combinational new-block placement check.
- On `start`, it captures the top two grid rows and a 2-row piece mask, then walks candidate column offsets one per cycle.
- It reports the first offset where the piece fits, together with the merged two-row image and the reference row/column.
- It sits between the game FSM (NEW_BLOCK state) and the grid write-back path. A `valid=0` result drives GAME_OVER.

Parameters:
- GRID_W, 10, grid width in cells.
- PIECE_W, 4, piece mask width in cells; legal range 1..GRID_W.
- COLOR_W, 3, bits per cell; 0 means empty.
- ROW_BASE, 21, value driven on `row_ref` for a successful spawn.
- CENTER_FIRST, 0, search order: 0 = left-to-right; 1 = centre-out.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- shape_mask  in  [1:0][PIECE_W-1:0]  piece occupancy. Index [0] is the top row; bit j maps to column offset+j.
- color  in  COLOR_W  fill colour for placed cells.
- row0  in  [GRID_W-1:0][COLOR_W-1:0]  top grid row.
- row1  in  [GRID_W-1:0][COLOR_W-1:0]  second grid row.
- busy  out  1  high while scanning.
- done  out  1  one-cycle pulse when the result is ready.
- valid  out  1  placement found; held until the next start.
- col_ref  out  $clog2(GRID_W)  chosen offset; held.
- row_ref  out  5  ROW_BASE on success, else 0; held.
- row01_out  out  [1:0][GRID_W-1:0][COLOR_W-1:0]  captured rows with the piece merged in; held.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state = IDLE.
  - busy, done, valid, col_ref, row_ref and row01_out all = 0.
  - Reset asserted mid-scan aborts the scan; no done pulse is produced.
- Definitions:
  - N = GRID_W-PIECE_W+1 candidate offsets.
  - Candidate o fits when, for every r in {0,1} and every j where shape_mask[r][j]=1, the captured row r has cell[o+j]==0.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - When start=1, capture row0, row1, shape_mask and color into internal registers.
  - Set busy=1, reset the step index k=0, and go to SCAN.
  - If the mask is all-zero or color==0, go directly to DONE with a failure result.
- SCAN:
  - Each cycle, evaluate candidate cand(k) against the captured data only; input changes after start are ignored.
  - If it fits: latch col_ref=cand(k), row_ref=ROW_BASE, valid=1, and row01_out = captured rows with the masked cells set to color. Go to DONE.
  - Else if k==N-1: latch valid=0, row_ref=0, col_ref=0, row01_out = captured rows unmodified. Go to DONE.
  - Else k++.
- DONE:
  - done=1 for exactly one cycle and busy=0, then return to IDLE.
- Search order, CENTER_FIRST=0: cand(k)=k.
- Search order, CENTER_FIRST=1:
  - c=(N-1)/2 (floor).
  - Sequence: c, c-1, c+1, c-2, c+2, …, skipping out-of-range values so that exactly N distinct offsets are visited.
  - For defaults (N=7): 3,2,4,1,5,0,6.
- Latency:
  - start is in cycle 0.
  - Candidate k is evaluated in cycle k+1.
  - done is asserted in cycle k+2 for the hit, or in cycle N+1 on failure.
  - Worst case is N+1 cycles after start.
  - Degenerate request (empty mask or color==0): done in cycle 1.
- start is ignored while busy or in DONE; no queueing.
- Outputs change only on a DONE transition or on reset. They hold between requests.
- Width rules:
  - The offset counter is $clog2(GRID_W) bits; o+j never exceeds GRID_W-1.
  - The centre-out index arithmetic is signed so that it never wraps.
- PIECE_W==GRID_W gives N=1: a single candidate, and done in cycle 2.

Test Plan:
- Empty rows, mask top=0000, bottom=0111, color=5, CENTER_FIRST=0, start → done in cycle 2, valid=1, col_ref=0, row_ref=21, row01_out[1][0..2]=5, everything else 0.
- Same request with row1 cells 0..3 = 2 → first fit at offset 4 (columns 4..6 free); done in cycle 6, col_ref=4, row01_out[1][4..6]=5, cells 0..3 still 2.
- CENTER_FIRST=1, empty rows, mask 0110/0110 → col_ref=3 and done in cycle 2. Then block columns 4 and 5 in row0 and repeat → candidates 3,2 both overlap, 4 overlaps, 1 fits (occupies columns 2..3): col_ref=1, done in cycle 5.
- row1 fully occupied, mask bottom=1111 → done in cycle 8 (N=7), valid=0, row_ref=0, row01_out equals the captured rows.
- Apply start; change row0/row1 while busy; pulse start again mid-scan → result reflects the captured data only, exactly one done pulse.
- Deassert rst_n during SCAN at cycle 3 → all outputs 0 immediately, no done. After release, start works normally. Also check mask=0 → done in cycle 1, valid=0.
